ccm_ctr_xor_buf: RTL

Consumer side of the CCM counter-mode keystream interface. Accepts 128-bit payload blocks, issues one keystream request pulse per block to the counter/AES stage (`input_en_buf`), holds each block in an in-order FIFO until its keystream word returns on `encrypt_data`/`encrypt_en`, then outputs payload XOR keystream with a trailing-byte mask for the final partial block. Sits between the payload source and the output formatter, in front of `ccm_ctr_dly_fake_aes` (or the real AES counter path).

---
 rtl/ccm_ctr_xor_buf.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ccm_ctr_xor_buf.sv
// ccm_ctr_xor_buf: payload buffer for the CCM counter-mode keystream path.
// Each accepted payload block raises one keystream request and waits in an
// in-order FIFO; when its keystream word returns the block is XORed with it,
// trailing bytes beyond the block length are zeroed, and the result is
// presented for one cycle.
module ccm_ctr_xor_buf #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] data_in,
    input  logic [4:0]   data_in_len,
    input  logic         data_in_en,
    output logic         data_in_rdy,
    output logic         input_en_buf,
    input  logic [127:0] encrypt_data,
    input  logic         encrypt_en,
    output logic [127:0] data_out,
    output logic [4:0]   data_out_len,
    output logic         data_out_en,
    output logic         err_underflow
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    // Lengths of 0 or above 16 mean a full 16-byte block.
    function automatic logic [4:0] norm_len(input logic [4:0] len);
        logic [4:0] r;
        r = len;
        if ((len == 5'd0) || (len > 5'd16)) begin
            r = 5'd16;
        end
        return r;
    endfunction

    // Keep byte i (byte 0 in the top bits) only when i < len.
    function automatic logic [127:0] byte_mask(input logic [4:0] len);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < len) begin
                m[127-8*i -: 8] = 8'hff;
            end
        end
        return m;
    endfunction

    logic [127:0]     data_mem_q [FIFO_DEPTH];
    logic [4:0]       len_mem_q  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q;
    logic             out_en_q;
    logic             err_q, err_d;
    logic [127:0]     out_data_q, out_data_d;
    logic [4:0]       out_len_q;

    logic             accept;
    logic             pop;
    logic [127:0]     head_data;
    logic [4:0]       head_len;

    // Occupancy equals outstanding keystream requests, so a pop always
    // pairs the FIFO head with the keystream word arriving now.
    assign data_in_rdy = (cnt_q < DEPTH_C);
    assign accept      = data_in_en & data_in_rdy;
    assign pop         = encrypt_en & (cnt_q != '0);
    assign head_data   = data_mem_q[rd_ptr_q];
    assign head_len    = len_mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy, sticky underflow and output word.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        out_data_d = (head_data ^ encrypt_data) & byte_mask(head_len);
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (encrypt_en && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // Control state: FIFO pointers, occupancy, request/valid pulses, error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            out_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            req_q    <= accept;
            out_en_q <= pop;
            err_q    <= err_d;
        end
    end

    // Output word and length, updated only on a pop and held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_q <= '0;
            out_len_q  <= '0;
        end else if (pop) begin
            out_data_q <= out_data_d;
            out_len_q  <= head_len;
        end
    end

    // Payload storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem_q[wr_ptr_q] <= data_in;
            len_mem_q[wr_ptr_q]  <= norm_len(data_in_len);
        end
    end

    assign input_en_buf  = req_q;
    assign data_out      = out_data_q;
    assign data_out_len  = out_len_q;
    assign data_out_en   = out_en_q;
    assign err_underflow = err_q;

endmodule
